// File: rtl/reply_packetizer.sv
// rtl/reply_packetizer.sv - buffers slave replies and emits them as head/body/tail NoC flits; optional macro REPLY_PACKETIZER_BYPASS_EN
module reply_packetizer #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int FLIT_DATA_WIDTH  = 32,
  parameter int NUM_FLITS        = 4,
  parameter int REPLY_DEPTH      = 4,
  localparam int DATA_WIDTH      = NUM_FLITS * FLIT_DATA_WIDTH,
  localparam int FLIT_WIDTH      = 2 + ADDRESS_WIDTH + VC_ADDRESS_WIDTH + FLIT_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       i_data_in,
  input  logic                        i_valid_in,
  output logic                        i_ready_out,
  input  logic [ADDRESS_WIDTH-1:0]    i_dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] i_vc_in,
  output logic                        o_dst_pop_out,
  output logic [FLIT_WIDTH-1:0]       o_flit_out,
  output logic                        o_valid_out,
  input  logic                        o_ready_in,
  output logic                        o_overflow_out
);

  localparam int CNT_W    = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam int PTR_W    = $clog2(REPLY_DEPTH);
  localparam int CW       = PTR_W + 1;
  localparam int CNT_LAST = NUM_FLITS - 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic [ADDRESS_WIDTH-1:0]    dst_q, dst_d;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q, vc_d;
  logic                        valid_q, valid_d;
  logic [FLIT_WIDTH-1:0]       flit_q, flit_d;
  logic                        ovf_q, ovf_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic [DATA_WIDTH-1:0]       mem_q [REPLY_DEPTH];

  logic                        empty, full, accept, last;
  logic                        load_fifo, load_byp, load, wr_en;
  logic [DATA_WIDTH-1:0]       load_data;

  // Flit word for slice c of a reply: head on the first slice, tail on the last.
  function automatic logic [FLIT_WIDTH-1:0] make_flit(
    input logic [CNT_W-1:0]            c,
    input logic [DATA_WIDTH-1:0]       d,
    input logic [ADDRESS_WIDTH-1:0]    dst,
    input logic [VC_ADDRESS_WIDTH-1:0] vc
  );
    make_flit = {c == CNT_W'(0), c == CNT_W'(CNT_LAST), dst, vc,
                 d[c*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH]};
  endfunction

  // Next-state: FIFO bookkeeping, packet load, flit advance and overflow flag.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    dst_d    = dst_q;
    vc_d     = vc_q;
    valid_d  = valid_q;
    flit_d   = flit_q;
    ovf_d    = ovf_q;

    empty    = (count_q == '0);
    full     = (count_q == CW'(REPLY_DEPTH));
    accept   = valid_q & o_ready_in;
    last     = (cnt_q == CNT_W'(CNT_LAST));

    // A new packet starts from the FIFO when idle, or back-to-back on tail acceptance.
    load_fifo = ~empty & ((state_q == IDLE) | (accept & last));
`ifdef REPLY_PACKETIZER_BYPASS_EN
    load_byp  = (state_q == IDLE) & empty & i_valid_in;
`else
    load_byp  = 1'b0;
`endif
    load      = load_fifo | load_byp;
    load_data = load_byp ? i_data_in : mem_q[rd_ptr_q];

    // The slave cannot be stalled: a write is taken if there is room after any pop.
    wr_en = i_valid_in & ~load_byp & (~full | load_fifo);
    if (i_valid_in & ~load_byp & full & ~load_fifo) begin
      ovf_d = 1'b1;
    end

    rd_ptr_d = rd_ptr_q + PTR_W'(load_fifo);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    count_d  = count_q + CW'(wr_en) - CW'(load_fifo);

    if (load) begin
      state_d = SEND;
      cnt_d   = '0;
      data_d  = load_data;
      dst_d   = i_dst_in;
      vc_d    = i_vc_in;
      valid_d = 1'b1;
      flit_d  = make_flit('0, load_data, i_dst_in, i_vc_in);
    end else if (accept) begin
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
        flit_d  = '0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        flit_d = make_flit(cnt_q + 1'b1, data_q, dst_q, vc_q);
      end
    end
  end

  // Control and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      dst_q    <= '0;
      vc_q     <= '0;
      valid_q  <= 1'b0;
      flit_q   <= '0;
      ovf_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      dst_q    <= dst_d;
      vc_q     <= vc_d;
      valid_q  <= valid_d;
      flit_q   <= flit_d;
      ovf_q    <= ovf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Reply storage; contents are don't-care once the count is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= i_data_in;
    end
  end

  assign i_ready_out    = ~full;
  assign o_dst_pop_out  = load & ~rst;
  assign o_flit_out     = flit_q;
  assign o_valid_out    = valid_q;
  assign o_overflow_out = ovf_q;

endmodule

// File: tb/tb_reply_packetizer.sv
// tb/tb_reply_packetizer.sv - randomized and directed self-checking bench for reply_packetizer
module tb_reply_packetizer;
  localparam int AW  = 4;
  localparam int VW  = 1;
  localparam int FDW = 32;
  localparam int NF  = 4;
  localparam int RD  = 4;
  localparam int DW  = NF * FDW;
  localparam int FW  = 2 + AW + VW + FDW;
`ifdef REPLY_PACKETIZER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_data_in;
  logic          i_valid_in;
  logic          i_ready_out;
  logic [AW-1:0] i_dst_in;
  logic [VW-1:0] i_vc_in;
  logic          o_dst_pop_out;
  logic [FW-1:0] o_flit_out;
  logic          o_valid_out;
  logic          o_ready_in;
  logic          o_overflow_out;

  reply_packetizer #(
    .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW), .FLIT_DATA_WIDTH(FDW),
    .NUM_FLITS(NF), .REPLY_DEPTH(RD)
  ) dut (
    .clk(clk), .rst(rst),
    .i_data_in(i_data_in), .i_valid_in(i_valid_in), .i_ready_out(i_ready_out),
    .i_dst_in(i_dst_in), .i_vc_in(i_vc_in), .o_dst_pop_out(o_dst_pop_out),
    .o_flit_out(o_flit_out), .o_valid_out(o_valid_out), .o_ready_in(o_ready_in),
    .o_overflow_out(o_overflow_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending replies, their destinations, the packet on the wire.
  logic [DW-1:0]    rq[$];
  logic [AW+VW-1:0] dq[$];
  bit               act;
  int               idx;
  logic [DW-1:0]    pdata;
  logic [AW+VW-1:0] pdv;
  bit               movf;
  logic [AW+VW-1:0] new_dv;

  logic          s_valid, s_pop, s_rdy, s_ovf;
  logic [FW-1:0] s_flit;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [AW+VW-1:0] dv,
                       input bit rdy, input bit r);
    i_valid_in = v;
    i_data_in  = d;
    new_dv     = dv;
    o_ready_in = rdy;
    rst        = r;
    if (dq.size() > 0) {i_dst_in, i_vc_in} = dq[0];
    else               {i_dst_in, i_vc_in} = dv;
  endtask

  task automatic step();
    bit            byp_now, tail_acc, fifo_load, load;
    logic [FW-1:0] ef;
    @(negedge clk);
    s_valid = o_valid_out;
    s_flit  = o_flit_out;
    s_pop   = o_dst_pop_out;
    s_rdy   = i_ready_out;
    s_ovf   = o_overflow_out;
    byp_now   = BYP && !act && rq.size() == 0 && i_valid_in;
    tail_acc  = act && o_ready_in && idx == NF - 1;
    fifo_load = rq.size() > 0 && (!act || tail_acc);
    load      = fifo_load || byp_now;
    chk("valid", 64'(s_valid), 64'(act));
    if (act) begin
      ef = {idx == 0, idx == NF - 1, pdv, pdata[idx*FDW +: FDW]};
      chk("flit", 64'(s_flit), 64'(ef));
    end
    chk("pop", 64'(s_pop), 64'(load && !rst));
    chk("ready_out", 64'(s_rdy), 64'(rq.size() < RD));
    chk("overflow", 64'(s_ovf), 64'(movf));
    @(posedge clk);
    if (rst) begin
      rq.delete();
      dq.delete();
      act  = 1'b0;
      idx  = 0;
      movf = 1'b0;
    end else begin
      if (load) begin
        act = 1'b1;
        idx = 0;
        pdv = {i_dst_in, i_vc_in};
        if (byp_now) pdata = i_data_in;
        else begin
          pdata = rq.pop_front();
          dq.delete(0);
        end
      end else if (act && o_ready_in) begin
        if (idx == NF - 1) act = 1'b0;
        else idx++;
      end
      if (i_valid_in && !byp_now) begin
        if (rq.size() < RD) begin
          rq.push_back(i_data_in);
          dq.push_back(new_dv);
        end else begin
          movf = 1'b1;
        end
      end
    end
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [DW-1:0] d0;
    logic [FDW-1:0] w;
    int pops, vcnt, stall, n;
    act = 1'b0; idx = 0; movf = 1'b0; pdata = '0; pdv = '0;
    drive(0, '0, '0, 1, 1);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    drive(0, '0, '0, 1, 0);
    step();
    chk("reset_valid", 64'(s_valid), 64'd0);
    chk("reset_flit", 64'(s_flit), 64'd0);
    chk("reset_pop", 64'(s_pop), 64'd0);
    chk("reset_ready", 64'(s_rdy), 64'd1);
    chk("reset_ovf", 64'(s_ovf), 64'd0);

    // Single reply, literal flits and latency
    d0 = 128'h44444444_33333333_22222222_11111111;
    drive(1, d0, {4'd5, 1'b1}, 1, 0);
    step();
    pops = int'(s_pop);
    chk("single_pop_T", 64'(s_pop), 64'(BYP));
    for (int i = 1; i < (BYP ? 1 : 2); i++) begin
      drive(0, '0, '0, 1, 0);
      step();
      pops += int'(s_pop);
      chk("single_no_valid_T1", 64'(s_valid), 64'd0);
    end
    for (int k = 0; k < NF; k++) begin
      drive(0, '0, '0, 1, 0);
      step();
      pops += int'(s_pop);
      w = d0[k*FDW +: FDW];
      chk("single_valid", 64'(s_valid), 64'd1);
      chk("single_flit", 64'(s_flit), 64'({k == 0, k == NF - 1, 4'd5, 1'b1, w}));
    end
    chk("single_pops", 64'(pops), 64'd1);
    drive(0, '0, '0, 1, 0);
    step();
    chk("single_idle_after", 64'(s_valid), 64'd0);

    // Stall while flit 1 is presented
    vcnt = 0;
    stall = 3;
    drive(1, rnd_data(), {4'd2, 1'b0}, 1, 0);
    step();
    vcnt += int'(s_valid);
    for (int i = 0; i < 14; i++) begin
      if (act && idx == 1 && stall > 0) begin
        stall--;
        drive(0, '0, '0, 0, 0);
      end else begin
        drive(0, '0, '0, 1, 0);
      end
      step();
      vcnt += int'(s_valid);
    end
    chk("stall_valid_cycles", 64'(vcnt), 64'd7);

    // Two back-to-back replies
    vcnt = 0;
    pops = 0;
    drive(1, rnd_data(), {4'd3, 1'b0}, 1, 0);
    step();
    vcnt += int'(s_valid); pops += int'(s_pop);
    drive(1, rnd_data(), {4'd9, 1'b1}, 1, 0);
    step();
    vcnt += int'(s_valid); pops += int'(s_pop);
    for (int i = 0; i < 10; i++) begin
      drive(0, '0, '0, 1, 0);
      step();
      vcnt += int'(s_valid); pops += int'(s_pop);
    end
    chk("b2b_valid_cycles", 64'(vcnt), 64'd8);
    chk("b2b_pops", 64'(pops), 64'd2);

    // Overflow with the NoC stalled
    drive(0, '0, '0, 0, 1);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1, rnd_data(), 5'($urandom), 0, 0);
      step();
    end
    chk("ovf_ready_T5", 64'(s_rdy), 64'd0);
    drive(0, '0, '0, 0, 0);
    step();
    chk("ovf_set_T6", 64'(s_ovf), 64'd1);
    drive(0, '0, '0, 0, 0);
    step();
    chk("ovf_sticky", 64'(s_ovf), 64'd1);

    // Reset in the middle of a packet
    drive(0, '0, '0, 1, 1);
    step();
    drive(1, rnd_data(), {4'd7, 1'b1}, 1, 0);
    step();
    n = 0;
    while (!(act && idx == 2) && n < 10) begin
      drive(0, '0, '0, 1, 0);
      step();
      n++;
    end
    drive(0, '0, '0, 1, 1);
    step();
    drive(0, '0, '0, 1, 0);
    step();
    chk("midrst_valid", 64'(s_valid), 64'd0);
    chk("midrst_ovf", 64'(s_ovf), 64'd0);
    drive(1, rnd_data(), {4'd4, 1'b0}, 1, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(0, '0, '0, 1, 0);
      step();
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 40, rnd_data(), 5'($urandom),
            $urandom_range(0, 99) < 70, $urandom_range(0, 299) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
